// File: rtl/posit_operand_decode_seq.sv
// Sequencer sharing one combinational posit field extractor between operands a and b.
// Decodes a then b on consecutive cycles and holds both results for the downstream core.
module posit_operand_decode_seq #(
    parameter int N  = 8,
    parameter int es = 2,
    parameter int Bs = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    output logic [N-1:0]    ext_in,
    input  logic            ext_rc,
    input  logic [Bs-1:0]   ext_regime,
    input  logic [es-1:0]   ext_exp,
    input  logic [N-es-1:0] ext_mant,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            a_sign,
    output logic            a_zero,
    output logic            a_nar,
    output logic            a_rc,
    output logic [Bs-1:0]   a_regime,
    output logic [es-1:0]   a_exp,
    output logic [N-es-1:0] a_mant,
    output logic            b_sign,
    output logic            b_zero,
    output logic            b_nar,
    output logic            b_rc,
    output logic [Bs-1:0]   b_regime,
    output logic [es-1:0]   b_exp,
    output logic [N-es-1:0] b_mant
);

    typedef enum logic [1:0] {IDLE, DEC_A, DEC_B, HOLD} state_t;

    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    state_t       state, state_nxt;
    logic [N-1:0] op_a, op_b;
    logic         a_special, b_special;

    // Two's complement of NaR is NaR itself, so it passes through unchanged.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] w);
        return w[N-1] ? (~w + 1'b1) : w;
    endfunction

    assign a_special = (op_a == '0) || (op_a == NAR_WORD);
    assign b_special = (op_b == '0) || (op_b == NAR_WORD);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ext_in    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = DEC_A;
            end
            DEC_A: begin
                ext_in    = magnitude(op_a);
                state_nxt = DEC_B;
            end
            DEC_B: begin
                ext_in    = magnitude(op_b);
                state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            a_sign   <= 1'b0;
            a_zero   <= 1'b0;
            a_nar    <= 1'b0;
            a_rc     <= 1'b0;
            a_regime <= '0;
            a_exp    <= '0;
            a_mant   <= '0;
            b_sign   <= 1'b0;
            b_zero   <= 1'b0;
            b_nar    <= 1'b0;
            b_rc     <= 1'b0;
            b_regime <= '0;
            b_exp    <= '0;
            b_mant   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                op_a <= in_a;
                op_b <= in_b;
            end
            // Extractor fields are only meaningful for non-special words.
            if (state == DEC_A) begin
                a_sign   <= op_a[N-1];
                a_zero   <= (op_a == '0);
                a_nar    <= (op_a == NAR_WORD);
                a_rc     <= a_special ? 1'b0 : ext_rc;
                a_regime <= a_special ? '0 : ext_regime;
                a_exp    <= a_special ? '0 : ext_exp;
                a_mant   <= a_special ? '0 : ext_mant;
            end
            if (state == DEC_B) begin
                b_sign   <= op_b[N-1];
                b_zero   <= (op_b == '0);
                b_nar    <= (op_b == NAR_WORD);
                b_rc     <= b_special ? 1'b0 : ext_rc;
                b_regime <= b_special ? '0 : ext_regime;
                b_exp    <= b_special ? '0 : ext_exp;
                b_mant   <= b_special ? '0 : ext_mant;
            end
        end
    end

endmodule

// File: tb/tb_posit_operand_decode_seq.sv
// Bench for posit_operand_decode_seq: behavioural posit extractor model plus
// directed and randomized operand pairs checked against a field-level reference.
module tb_posit_operand_decode_seq;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_a, in_b, ext_in;
    logic       ext_rc;
    logic [2:0] ext_regime;
    logic [1:0] ext_exp;
    logic [5:0] ext_mant;
    logic       a_sign, a_zero, a_nar, a_rc, b_sign, b_zero, b_nar, b_rc;
    logic [2:0] a_regime, b_regime;
    logic [1:0] a_exp, b_exp;
    logic [5:0] a_mant, b_mant;
    logic       garbage = 1'b0;

    int total = 0;
    int passed = 0;
    int fails = 0;

    posit_operand_decode_seq #(.N(8), .es(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .ext_in(ext_in), .ext_rc(ext_rc),
        .ext_regime(ext_regime), .ext_exp(ext_exp), .ext_mant(ext_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_sign(a_sign), .a_zero(a_zero), .a_nar(a_nar), .a_rc(a_rc),
        .a_regime(a_regime), .a_exp(a_exp), .a_mant(a_mant),
        .b_sign(b_sign), .b_zero(b_zero), .b_nar(b_nar), .b_rc(b_rc),
        .b_regime(b_regime), .b_exp(b_exp), .b_mant(b_mant)
    );

    always #5 clk = ~clk;

    // Positive posit magnitude -> {rc, regime, exp, mant}
    function automatic logic [11:0] ext_model(input logic [7:0] x);
        int unsigned k;
        logic        rc;
        logic [7:0]  sh;
        logic [2:0]  rv;
        rc = x[6];
        k  = 0;
        while (k < 7 && x[6-k] == rc) k++;
        sh = x << (k + 2);
        rv = rc ? 3'(k - 1) : 3'(k);
        return {rc, rv, sh[7:6], sh[5:0]};
    endfunction

    always_comb begin
        if (garbage) {ext_rc, ext_regime, ext_exp, ext_mant} = '1;
        else         {ext_rc, ext_regime, ext_exp, ext_mant} = ext_model(ext_in);
    end

    function automatic logic [14:0] ref_fields(input logic [7:0] op);
        logic       zero, nar;
        logic [7:0] mag;
        zero = (op == 8'h00);
        nar  = (op == 8'h80);
        mag  = op[7] ? 8'(256 - int'(op)) : op;
        return {op[7], zero, nar, (zero || nar) ? 12'h000 : ext_model(mag)};
    endfunction

    function automatic logic [14:0] dut_a();
        return {a_sign, a_zero, a_nar, a_rc, a_regime, a_exp, a_mant};
    endfunction

    function automatic logic [14:0] dut_b();
        return {b_sign, b_zero, b_nar, b_rc, b_regime, b_exp, b_mant};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pa, pb, qa, qb;
        logic [7:0] sa[10], sb[10];
        logic [7:0] qa_q[$], qb_q[$];
        logic       stable, leaked;
        int         sent, got, cyc, last_cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ext_in", 32'(ext_in), 0);
        chk("rst_a_fields", 32'(dut_a()), 0);
        chk("rst_b_fields", 32'(dut_b()), 0);

        // Negative operand a, plus operand change right after acceptance
        in_a = 8'hC0; in_b = 8'h30; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_a = 8'h11; in_b = 8'h22;
        chk("neg_ext_a", 32'(ext_in), 32'h40);
        chk("neg_in_ready_busy", 32'(in_ready), 0);
        tick();
        chk("neg_ext_b", 32'(ext_in), 32'h30);
        tick();
        chk("neg_out_valid", 32'(out_valid), 1);
        chk("neg_a_fields", 32'(dut_a()), 32'(ref_fields(8'hC0)));
        chk("neg_b_fields", 32'(dut_b()), 32'(ref_fields(8'h30)));
        chk("neg_a_sign", 32'(a_sign), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("neg_release", 32'({out_valid, in_ready}), 32'b01);

        // Reset for two cycles while decoding operand b
        in_a = 8'h5A; in_b = 8'hA7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_ext_b", 32'(ext_in), 32'h59);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_ext_in", 32'(ext_in), 0);
        chk("mid_rst_fields", 32'({dut_a(), dut_b()}), 0);
        out_ready = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) leaked = 1'b1;
        end
        chk("mid_rst_no_emit", 32'(leaked), 0);
        out_ready = 1'b0;

        // Specials with a garbage-producing extractor
        garbage = 1'b1;
        in_a = 8'h00; in_b = 8'h80; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("spec_ext_nar", 32'(ext_in), 32'h80);
        tick();
        chk("spec_a_fields", 32'(dut_a()), 32'(ref_fields(8'h00)));
        chk("spec_b_fields", 32'(dut_b()), 32'(ref_fields(8'h80)));
        garbage = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure in HOLD with new operands pushed meanwhile
        pa = 8'($urandom); pb = 8'($urandom);
        qa = 8'($urandom); qb = 8'($urandom);
        in_a = pa; in_b = pb; in_valid = 1'b1;
        tick();
        in_a = qa; in_b = qb;
        tick(); tick();
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || in_ready) stable = 1'b0;
            if (dut_a() !== ref_fields(pa) || dut_b() !== ref_fields(pb)) stable = 1'b0;
            tick();
        end
        chk("bp_hold_stable", 32'(stable), 1);
        chk("bp_a_fields", 32'(dut_a()), 32'(ref_fields(pa)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("bp_next_a", 32'(dut_a()), 32'(ref_fields(qa)));
        chk("bp_next_b", 32'(dut_b()), 32'(ref_fields(qb)));
        out_ready = 1'b1;
        tick();

        // Streaming of random pairs with out_ready held high
        for (int i = 0; i < 10; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
        end
        sa[3] = 8'h80; sb[7] = 8'h00;
        sent = 0; got = 0; last_cyc = -1; cyc = 0;
        while (got < 10 && cyc < 300) begin
            if (out_valid) begin
                chk("stream_a", 32'(dut_a()), 32'(ref_fields(qa_q.pop_front())));
                chk("stream_b", 32'(dut_b()), 32'(ref_fields(qb_q.pop_front())));
                if (last_cyc >= 0) chk("stream_gap", 32'(cyc - last_cyc), 4);
                last_cyc = cyc;
                got++;
            end
            if (in_ready && sent < 10) begin
                in_a = sa[sent]; in_b = sb[sent];
                qa_q.push_back(sa[sent]); qb_q.push_back(sb[sent]);
                sent++;
                in_valid = 1'b1;
            end else begin
                in_a = 8'($urandom); in_b = 8'($urandom);
                in_valid = (sent < 10);
            end
            tick();
            cyc++;
        end
        chk("stream_count", 32'(got), 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/posit_operand_decode_seq.md
Name: posit_operand_decode_seq

Overview:
- Sequencer that shares one combinational posit field extractor between the two operands of a posit arithmetic op (a, b).
- Accepts an operand pair over a valid/ready handshake and drives the extractor with each operand's magnitude in turn, over two consecutive cycles.
- Registers the returned fields plus sign/zero/NaR flags and presents both decoded operands to the downstream mul/add core over a valid/ready handshake.

Parameters:
- N, 8, posit word width.
- es, 2, exponent field width.
- Bs, log2(N) (ceiling), regime/shift field width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  N  operand a, posit two's-complement encoding.
- in_b  in  N  operand b.
- ext_in  out  N  magnitude word driven to the shared extractor.
- ext_rc  in  1  extractor regime-check bit.
- ext_regime  in  Bs  extractor regime run value.
- ext_exp  in  es  extractor exponent field.
- ext_mant  in  N-es  extractor mantissa field.
- out_valid  out  1  decoded pair valid.
- out_ready  in  1  downstream accepts.
- a_sign, a_zero, a_nar, a_rc  out  1 each  operand a flags.
- a_regime  out  Bs  operand a regime.
- a_exp  out  es  operand a exponent.
- a_mant  out  N-es  operand a mantissa.
- b_sign, b_zero, b_nar, b_rc, b_regime, b_exp, b_mant  out  same widths  operand b fields.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- FSM states: IDLE, DEC_A, DEC_B, HOLD. Reset forces IDLE.
- On reset, every output register is 0: out_valid=0, all a_*/b_* = 0, ext_in = 0. in_ready=1 in the first cycle after reset.
- in_ready = (state==IDLE), combinational from state only; no dependency on out_ready.
- IDLE:
  - When in_valid && in_ready, latch in_a/in_b into op_a/op_b and go to DEC_A.
  - ext_in = 0.
- DEC_A:
  - ext_in = op_a[N-1] ? (~op_a + 1) : op_a, truncated to N bits.
  - At the edge, capture ext_rc/ext_regime/ext_exp/ext_mant into a_*.
  - a_sign = op_a[N-1]; a_zero = (op_a==0); a_nar = (op_a == 1 followed by N-1 zeros).
  - If a_zero or a_nar, force a_rc, a_regime, a_exp, a_mant to 0 regardless of the extractor outputs.
  - Next state is DEC_B.
- DEC_B: same as DEC_A using op_b and the b_* fields. Next state is HOLD.
- HOLD:
  - out_valid = 1; ext_in = 0.
  - a_*/b_* are held stable while out_valid && !out_ready.
  - When out_ready, go to IDLE with out_valid=0 on the next cycle.
- Extractor contract: the extractor is purely combinational. Its fields are sampled in the same cycle ext_in is driven; no wait states.
- Latency and throughput:
  - Pair accepted at edge T gives out_valid=1 from cycle T+3.
  - With out_ready held high, throughput is one pair per 4 cycles.
- in_valid during DEC_A/DEC_B/HOLD is ignored: in_ready=0, and op_a/op_b do not change.
- NaR negation: two's complement of NaR is NaR. ext_in = 1 followed by N-1 zeros in that cycle is legal, and the result is overridden by the flag rule.
- Reset mid-operation (any state): next cycle is IDLE with all outputs 0. The in-flight pair is discarded and never emitted.
- out_ready while not in HOLD has no effect.
- a_* fields are not updated during DEC_B or HOLD; b_* fields are not updated during DEC_A or HOLD.

Test Plan:
- Reset/idle: assert rst 2 cycles mid-DEC_B -> next cycle IDLE, in_ready=1, out_valid=0, all fields 0, ext_in=0.
- Negative operand (N=8, es=2): in_a=0xC0, in_b=0x30, in_valid pulse at T.
  - ext_in=0x40 at T+1, then 0x30 at T+2.
  - out_valid at T+3 with a_sign=1, b_sign=0.
  - a_*/b_* fields equal the extractor model outputs for 0x40/0x30.
- Specials: in_a=0x00, in_b=0x80.
  - Result: a_zero=1, b_nar=1.
  - All a/b regime/exp/mant/rc = 0, even when the bench's extractor model returns nonzero garbage.
- Backpressure: out_ready=0 for 5 cycles in HOLD, with in_valid held high and new operands applied.
  - out_valid stays 1, fields stable, in_ready=0.
  - After out_ready=1, the next pair is accepted in IDLE; the earlier operands are never corrupted.
- Streaming: 10 random pairs with out_ready=1 constantly -> one output every 4 cycles, in order, all fields matching the reference model.
- Latch check: change in_a/in_b on the cycle after acceptance -> ext_in still reflects the latched values.
